// File: rtl/operand_fetch_pkg.sv
// Shared constants for the operand fetch stage and its scoreboard.
package operand_fetch_pkg;

    localparam int DW    = 32;        // operand / register data width
    localparam int AW    = 5;         // register address width
    localparam int NREGS = 1 << AW;   // architectural register count
    localparam int SCW   = 16;        // stall counter width

    // Register 0 is hardwired to zero and is never tracked as in flight.
    localparam logic [AW-1:0] REG_ZERO = '0;

    function automatic logic is_nonzero(input logic [AW-1:0] r);
        return r != REG_ZERO;
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Bus bundle around operand_fetch: decode side, register file read and
// writeback taps, flush, execute side and the stall counter.
interface operand_fetch_if
    import operand_fetch_pkg::*;
();

    logic           in_valid;
    logic           in_ready;
    logic [AW-1:0]  in_raA;
    logic [AW-1:0]  in_raB;
    logic           in_useA;
    logic           in_useB;
    logic [AW-1:0]  in_wa;
    logic           in_wen;
    logic [AW-1:0]  rf_raA;
    logic [AW-1:0]  rf_raB;
    logic [DW-1:0]  rf_rdA;
    logic [DW-1:0]  rf_rdB;
    logic           wb_wen;
    logic [AW-1:0]  wb_wa;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_opA;
    logic [DW-1:0]  out_opB;
    logic [AW-1:0]  out_wa;
    logic           out_wen;
    logic [SCW-1:0] stall_cnt;

    // View of the operand fetch block itself.
    modport slave (
        input  in_valid, in_raA, in_raB, in_useA, in_useB, in_wa, in_wen,
        input  rf_rdA, rf_rdB, wb_wen, wb_wa, flush, out_ready,
        output in_ready, rf_raA, rf_raB,
        output out_valid, out_opA, out_opB, out_wa, out_wen, stall_cnt
    );

    // View of the surroundings: decode, register file, writeback and execute.
    modport master (
        output in_valid, in_raA, in_raB, in_useA, in_useB, in_wa, in_wen,
        output rf_rdA, rf_rdB, wb_wen, wb_wa, flush, out_ready,
        input  in_ready, rf_raA, rf_raB,
        input  out_valid, out_opA, out_opB, out_wa, out_wen, stall_cnt
    );

endinterface

// File: rtl/operand_fetch_sb.sv
// In-flight destination scoreboard. One pending bit per register; a
// writeback clear in the current cycle already hides the bit on the
// busy outputs. A set and a clear of the same register in one cycle
// leave the bit set, because the new writer is still outstanding.
module sb_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    input  logic [AW-1:0] chk_addr,
    output logic          busy_a,
    output logic          busy_b,
    output logic          busy_chk
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic [NREGS-1:0] clr_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_bit
            assign clr_vec[gi] = clr_en && (clr_addr == AW'(gi));
            if (gi == 0) begin : g_zero
                assign pending_d[gi] = 1'b0;
            end else begin : g_reg
                assign pending_d[gi] = (set_en && (set_addr == AW'(gi)))
                                     | (pending_q[gi] & ~clr_vec[gi]);
            end
        end
    endgenerate

    assign busy_a   = pending_q[rd_addr_a] & ~clr_vec[rd_addr_a];
    assign busy_b   = pending_q[rd_addr_b] & ~clr_vec[rd_addr_b];
    assign busy_chk = pending_q[chk_addr]  & ~clr_vec[chk_addr];

    // Pending bits update once per cycle from the set/clear next-state vector.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: drives register file read addresses, stalls on RAW/WAW
// hazards against in-flight destinations, registers operands into a
// valid/ready output stage and counts hazard stall cycles.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    operand_fetch_if.slave bus
);

    logic           busy_a;
    logic           busy_b;
    logic           busy_dest;
    logic           hazard;
    logic           ready;
    logic           accept;
    logic           set_en;
    logic [DW-1:0]  op_a_d;
    logic [DW-1:0]  op_b_d;

    logic           out_valid_q;
    logic [DW-1:0]  out_opa_q;
    logic [DW-1:0]  out_opb_q;
    logic [AW-1:0]  out_wa_q;
    logic           out_wen_q;
    logic [SCW-1:0] stall_cnt_q;

    // Register file writes on the falling edge, so the read data seen at the
    // capturing rising edge already includes a same-cycle writeback.
    assign bus.rf_raA = bus.in_raA;
    assign bus.rf_raB = bus.in_raB;

    assign set_en = accept && bus.in_wen && is_nonzero(bus.in_wa);

    sb_scoreboard u_sb (
        .clock     (clock),
        .reset     (reset),
        .set_en    (set_en),
        .set_addr  (bus.in_wa),
        .clr_en    (bus.wb_wen),
        .clr_addr  (bus.wb_wa),
        .rd_addr_a (bus.in_raA),
        .rd_addr_b (bus.in_raB),
        .chk_addr  (bus.in_wa),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .busy_chk  (busy_dest)
    );

    assign hazard = (bus.in_useA && busy_a)
                  | (bus.in_useB && busy_b)
                  | (bus.in_wen && is_nonzero(bus.in_wa) && busy_dest);
    assign ready  = !hazard && (!out_valid_q || bus.out_ready) && !bus.flush;
    assign accept = bus.in_valid && ready;
    assign bus.in_ready = ready;

    // Operand select: unused sources and register 0 read as zero.
    always_comb begin
        op_a_d = '0;
        op_b_d = '0;
        if (bus.in_useA && is_nonzero(bus.in_raA)) begin
            op_a_d = bus.rf_rdA;
        end
        if (bus.in_useB && is_nonzero(bus.in_raB)) begin
            op_b_d = bus.rf_rdB;
        end
    end

    // Output stage: load on accept, drain on consume or flush, otherwise hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_opa_q   <= '0;
            out_opb_q   <= '0;
            out_wa_q    <= '0;
            out_wen_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_opa_q   <= op_a_d;
            out_opb_q   <= op_b_d;
            out_wa_q    <= bus.in_wa;
            out_wen_q   <= bus.in_wen;
        end else if (bus.flush || bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Saturating count of cycles where a presented instruction is hazard-blocked.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (bus.in_valid && hazard && (stall_cnt_q != {SCW{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + SCW'(1);
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_opA   = out_opa_q;
    assign bus.out_opB   = out_opb_q;
    assign bus.out_wa    = out_wa_q;
    assign bus.out_wen   = out_wen_q;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a falling-edge register file model.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic          clock;
    logic          reset;
    logic          force_a;
    logic [DW-1:0] wb_wd;
    logic [DW-1:0] rf [NREGS];
    logic [NREGS-1:0] pend;
    int            tests_run;
    int            fails;

    operand_fetch_if ifc ();

    operand_fetch dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    assign pend = dut.u_sb.pending_q;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file model: combinational read, falling-edge write.
    assign ifc.rf_rdA = force_a ? 32'h0000_1234 : rf[ifc.rf_raA];
    assign ifc.rf_rdB = rf[ifc.rf_raB];

    always @(negedge clock) begin
        if (ifc.wb_wen) rf[ifc.wb_wa] <= wb_wd;
    end

    always @(posedge clock) begin
        if (reset && ifc.in_valid && ifc.in_ready)
            $display("[TB] accept raA=%0d useA=%0d raB=%0d useB=%0d wa=%0d wen=%0d",
                     ifc.in_raA, ifc.in_useA, ifc.in_raB, ifc.in_useB, ifc.in_wa, ifc.in_wen);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ifc.in_valid  = 1'b0;
        ifc.in_raA    = '0;
        ifc.in_raB    = '0;
        ifc.in_useA   = 1'b0;
        ifc.in_useB   = 1'b0;
        ifc.in_wa     = '0;
        ifc.in_wen    = 1'b0;
        ifc.wb_wen    = 1'b0;
        ifc.wb_wa     = '0;
        ifc.flush     = 1'b0;
        ifc.out_ready = 1'b0;
        force_a       = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic issue(input logic [AW-1:0] ra, input logic ua, input logic [AW-1:0] rb,
                         input logic ub, input logic [AW-1:0] wa, input logic we);
        ifc.in_valid = 1'b1;
        ifc.in_raA   = ra;
        ifc.in_useA  = ua;
        ifc.in_raB   = rb;
        ifc.in_useB  = ub;
        ifc.in_wa    = wa;
        ifc.in_wen   = we;
    endtask

    task automatic test_reset();
        // held in reset from time zero
        #3;
        tests_run++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %0h want 0", ifc.out_valid); end
        tests_run++; if (ifc.stall_cnt !== 16'h0) begin fails++; $display("FAIL rst_stall_cnt: got %h want 0000", ifc.stall_cnt); end
        tests_run++; if (pend !== 32'h0) begin fails++; $display("FAIL rst_pending: got %h want 00000000", pend); end
        tests_run++; if ({ifc.out_opA, ifc.out_opB} !== 64'h0) begin fails++; $display("FAIL rst_ops: got %h %h want 0 0", ifc.out_opA, ifc.out_opB); end
        tests_run++; if ({ifc.out_wa, ifc.out_wen} !== 6'h0) begin fails++; $display("FAIL rst_wa_wen: got %0d %0d want 0 0", ifc.out_wa, ifc.out_wen); end
        tests_run++; if (ifc.in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %0h want 1", ifc.in_ready); end
        reset = 1'b1;
        tick();
        // traffic: one accepted writer to r3, then a RAW reader stalls two cycles
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        tick();
        issue(5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1);
        tick();
        tick();
        tests_run++; if (ifc.out_valid !== 1'b1) begin fails++; $display("FAIL mid_out_valid: got %0h want 1", ifc.out_valid); end
        tests_run++; if (ifc.stall_cnt !== 16'd2) begin fails++; $display("FAIL mid_stall_cnt: got %0d want 2", ifc.stall_cnt); end
        // asynchronous reset between clock edges
        #2;
        reset = 1'b0;
        #1;
        tests_run++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL async_out_valid: got %0h want 0", ifc.out_valid); end
        tests_run++; if (ifc.stall_cnt !== 16'h0) begin fails++; $display("FAIL async_stall_cnt: got %h want 0000", ifc.stall_cnt); end
        tests_run++; if (pend !== 32'h0) begin fails++; $display("FAIL async_pending: got %h want 00000000", pend); end
        idle_inputs();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_raw_hazard();
        apply_reset();
        ifc.out_ready = 1'b1;
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        tick();
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
        #1;
        tests_run++; if (ifc.in_ready !== 1'b0) begin fails++; $display("FAIL raw_in_ready: got %0h want 0", ifc.in_ready); end
        tests_run++; if (ifc.rf_raA !== 5'd5) begin fails++; $display("FAIL raw_rf_raA: got %0d want 5", ifc.rf_raA); end
        tick();
        tick();
        tick();
        tests_run++; if (ifc.stall_cnt !== 16'd3) begin fails++; $display("FAIL raw_stall_cnt: got %0d want 3", ifc.stall_cnt); end
        tests_run++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL raw_drained: got %0h want 0", ifc.out_valid); end
        ifc.wb_wen = 1'b1;
        ifc.wb_wa  = 5'd5;
        wb_wd      = 32'hDEAD_BEEF;
        #1;
        tests_run++; if (ifc.in_ready !== 1'b1) begin fails++; $display("FAIL raw_clear_ready: got %0h want 1", ifc.in_ready); end
        tick();
        ifc.wb_wen   = 1'b0;
        ifc.in_valid = 1'b0;
        tests_run++; if (ifc.out_opA !== 32'hDEAD_BEEF) begin fails++; $display("FAIL raw_opA: got %h want deadbeef", ifc.out_opA); end
        tests_run++; if ({ifc.out_valid, ifc.out_wa, ifc.out_wen} !== {1'b1, 5'd6, 1'b1}) begin fails++; $display("FAIL raw_out_ctl: got v=%0d wa=%0d wen=%0d want 1 6 1", ifc.out_valid, ifc.out_wa, ifc.out_wen); end
        tests_run++; if (pend !== 32'h0000_0040) begin fails++; $display("FAIL raw_pending: got %h want 00000040", pend); end
        tests_run++; if (ifc.stall_cnt !== 16'd3) begin fails++; $display("FAIL raw_stall_hold: got %0d want 3", ifc.stall_cnt); end
    endtask

    task automatic test_zero_reg();
        apply_reset();
        ifc.out_ready = 1'b1;
        force_a = 1'b1;
        issue(5'd0, 1'b1, 5'd4, 1'b1, 5'd0, 1'b1);
        tick();
        tests_run++; if (ifc.out_opA !== 32'h0) begin fails++; $display("FAIL zero_opA: got %h want 00000000", ifc.out_opA); end
        tests_run++; if (ifc.out_opB !== 32'h1000_0004) begin fails++; $display("FAIL zero_opB: got %h want 10000004", ifc.out_opB); end
        tests_run++; if (pend !== 32'h0) begin fails++; $display("FAIL zero_pending: got %h want 00000000", pend); end
        issue(5'd2, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1);
        tick();
        tests_run++; if (ifc.out_opA !== 32'h0000_1234) begin fails++; $display("FAIL nouse_opA: got %h want 00001234", ifc.out_opA); end
        tests_run++; if (ifc.out_opB !== 32'h0) begin fails++; $display("FAIL nouse_opB: got %h want 00000000", ifc.out_opB); end
        tests_run++; if (pend !== 32'h0) begin fails++; $display("FAIL zero_pending2: got %h want 00000000", pend); end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        apply_reset();
        issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1);
        tick();
        tests_run++; if ({ifc.out_opA, ifc.out_opB} !== {32'h1000_0001, 32'h1000_0002}) begin fails++; $display("FAIL bp_first: got %h %h want 10000001 10000002", ifc.out_opA, ifc.out_opB); end
        issue(5'd3, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++; if (ifc.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d]: got %0h want 0", i, ifc.in_ready); end
            tick();
            tests_run++; if ({ifc.out_valid, ifc.out_opA, ifc.out_wa} !== {1'b1, 32'h1000_0001, 5'd9}) begin fails++; $display("FAIL bp_hold[%0d]: got v=%0d opA=%h wa=%0d want 1 10000001 9", i, ifc.out_valid, ifc.out_opA, ifc.out_wa); end
        end
        ifc.out_ready = 1'b1;
        #1;
        tests_run++; if (ifc.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %0h want 1", ifc.in_ready); end
        tick();
        tests_run++; if ({ifc.out_valid, ifc.out_opA, ifc.out_wa} !== {1'b1, 32'h1000_0003, 5'd10}) begin fails++; $display("FAIL b2b_first: got v=%0d opA=%h wa=%0d want 1 10000003 10", ifc.out_valid, ifc.out_opA, ifc.out_wa); end
        issue(5'd4, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1);
        tick();
        tests_run++; if ({ifc.out_valid, ifc.out_opA, ifc.out_wa} !== {1'b1, 32'h1000_0004, 5'd11}) begin fails++; $display("FAIL b2b_second: got v=%0d opA=%h wa=%0d want 1 10000004 11", ifc.out_valid, ifc.out_opA, ifc.out_wa); end
        ifc.in_valid = 1'b0;
        tick();
        tests_run++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %0h want 0", ifc.out_valid); end
        tests_run++; if (pend !== 32'h0000_0E00) begin fails++; $display("FAIL b2b_pending: got %h want 00000e00", pend); end
    endtask

    task automatic test_waw_same_cycle();
        apply_reset();
        ifc.out_ready = 1'b1;
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        tick();
        tests_run++; if (pend !== 32'h0000_0080) begin fails++; $display("FAIL waw_set: got %h want 00000080", pend); end
        #1;
        tests_run++; if (ifc.in_ready !== 1'b0) begin fails++; $display("FAIL waw_block: got %0h want 0", ifc.in_ready); end
        ifc.wb_wen = 1'b1;
        ifc.wb_wa  = 5'd7;
        #1;
        tests_run++; if (ifc.in_ready !== 1'b1) begin fails++; $display("FAIL waw_clear_ready: got %0h want 1", ifc.in_ready); end
        tick();
        ifc.wb_wen   = 1'b0;
        ifc.in_valid = 1'b0;
        tests_run++; if (pend !== 32'h0000_0080) begin fails++; $display("FAIL waw_set_wins: got %h want 00000080", pend); end
        tests_run++; if ({ifc.out_valid, ifc.out_wa} !== {1'b1, 5'd7}) begin fails++; $display("FAIL waw_out: got v=%0d wa=%0d want 1 7", ifc.out_valid, ifc.out_wa); end
    endtask

    task automatic test_saturate_flush();
        apply_reset();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1);
        tick();
        issue(5'd8, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1);
        for (int i = 0; i < 66000; i++) tick();
        tests_run++; if (ifc.stall_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_stall_cnt: got %h want ffff", ifc.stall_cnt); end
        tests_run++; if (ifc.out_valid !== 1'b1) begin fails++; $display("FAIL sat_out_valid: got %0h want 1", ifc.out_valid); end
        issue(5'd1, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1);
        ifc.out_ready = 1'b1;
        ifc.flush     = 1'b1;
        #1;
        tests_run++; if (ifc.in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready: got %0h want 0", ifc.in_ready); end
        tick();
        ifc.flush = 1'b0;
        ifc.in_valid = 1'b0;
        tests_run++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL flush_out_valid: got %0h want 0", ifc.out_valid); end
        tests_run++; if (pend !== 32'h0000_0100) begin fails++; $display("FAIL flush_pending: got %h want 00000100", pend); end
        tests_run++; if (ifc.stall_cnt !== 16'hFFFF) begin fails++; $display("FAIL flush_stall_hold: got %h want ffff", ifc.stall_cnt); end
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        wb_wd     = '0;
        for (int i = 0; i < NREGS; i++) rf[i] = 32'h1000_0000 | i;
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_raw_hazard();
        test_zero_reg();
        test_backpressure();
        test_waw_same_cycle();
        test_saturate_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
